bp_be_fence_sequencer: RTL and testbench

- Sequences committed fence, fence.i and sfence.vma in the backend.
- Holds dispatch and drains outstanding D$ traffic (credits and cache idle).
- For sfence.vma, pulses the D-TLB flush; for fence.i and sfence.vma, issues the matching FE command with a ready handshake and waits for the FE to finish.
- Sits between the commit stage and the checker, and is the only source of fence-type FE commands.

---
 rtl/bp_be_pkg.sv | 23 ++
 rtl/bp_be_fence_watchdog.sv | 43 ++++
 rtl/bp_be_fence_sequencer.sv | 120 ++++++++++++
 tb/tb_bp_be_fence_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared backend types for fence sequencing: fence kinds, sequencer states and FE fence ops.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_fence      = 2'd0,
        e_fencei     = 2'd1,
        e_sfence_vma = 2'd2
    } bp_be_fence_type_e;

    typedef enum logic [2:0] {
        e_fseq_idle    = 3'd0,
        e_fseq_drain   = 3'd1,
        e_fseq_flush   = 3'd2,
        e_fseq_send    = 3'd3,
        e_fseq_wait_fe = 3'd4,
        e_fseq_done    = 3'd5
    } bp_be_fence_state_e;

    localparam logic [1:0] e_fe_op_none         = 2'd0;
    localparam logic [1:0] e_fe_op_icache_fence = 2'd1;
    localparam logic [1:0] e_fe_op_itlb_fence   = 2'd2;

endpackage

// File: rtl/bp_be_fence_watchdog.sv
// Saturating wait-cycle counter with synchronous clear and a sticky overflow flag.
// The flag sets on the edge where the count reaches timeout_p and holds until reset.
module bp_be_fence_watchdog #(
    parameter int timeout_p = 4096
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               clear_i,
    input  logic                               en_i,
    output logic [$clog2(timeout_p+1)-1:0]     count_o,
    output logic                               timeout_o
);

    localparam int                    cnt_width_lp = $clog2(timeout_p+1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_p);
    localparam logic [cnt_width_lp-1:0] cnt_pre_lp = cnt_width_lp'(timeout_p - 1);

    logic [cnt_width_lp-1:0] r_cnt;
    logic                    r_timeout;
    logic                    w_inc;

    assign w_inc = en_i && !clear_i && (r_cnt != cnt_max_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (clear_i) begin
                r_cnt <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_inc && (r_cnt == cnt_pre_lp)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign count_o   = r_cnt;
    assign timeout_o = r_timeout;

endmodule

// File: rtl/bp_be_fence_sequencer.sv
// Sequences committed fence / fence.i / sfence.vma: drain D$, optional D-TLB flush, FE command, wait, done.
// Outputs are pure decodes of registered state; dispatch is held (busy_o) in every non-idle state.
module bp_be_fence_sequencer
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int timeout_p     = 4096
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     fence_v_i,
    output logic                     fence_ready_o,
    input  logic [1:0]               fence_type_i,
    input  logic [vaddr_width_p-1:0] fence_npc_i,
    output logic                     busy_o,
    input  logic                     credits_empty_i,
    input  logic                     dcache_idle_i,
    output logic                     dtlb_flush_o,
    output logic                     fe_cmd_v_o,
    output logic [1:0]               fe_cmd_op_o,
    output logic [vaddr_width_p-1:0] fe_cmd_pc_o,
    input  logic                     fe_cmd_ready_i,
    input  logic                     fe_cmd_fence_i,
    output logic                     fence_done_o,
    output logic                     timeout_o
);

    localparam int wd_width_lp = $clog2(timeout_p+1);

    bp_be_fence_state_e        r_state;
    bp_be_fence_state_e        w_state_n;
    logic [1:0]                r_type;
    logic [vaddr_width_p-1:0]  r_pc;
    logic                      w_accept;
    logic                      w_counting;
    logic [wd_width_lp-1:0]    w_wd_cnt;
    logic                      w_wd_timeout;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_fseq_idle;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_type <= 2'd0;
            r_pc   <= '0;
        end else if (w_accept) begin
            r_type <= fence_type_i;
            r_pc   <= fence_npc_i;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_accept  = 1'b0;
        case (r_state)
            e_fseq_idle: begin
                if (fence_v_i) begin
                    w_accept  = 1'b1;
                    w_state_n = e_fseq_drain;
                end
            end
            e_fseq_drain: begin
                if (credits_empty_i && dcache_idle_i) begin
                    if (r_type == e_sfence_vma) begin
                        w_state_n = e_fseq_flush;
                    end else if (r_type == e_fencei) begin
                        w_state_n = e_fseq_send;
                    end else begin
                        w_state_n = e_fseq_done;
                    end
                end
            end
            e_fseq_flush: w_state_n = e_fseq_send;
            e_fseq_send: begin
                if (fe_cmd_ready_i) begin
                    w_state_n = e_fseq_wait_fe;
                end
            end
            e_fseq_wait_fe: begin
                // Count is zero only in the first WAIT_FE cycle, where fe_cmd_fence_i may not have risen yet.
                if ((w_wd_cnt != '0) && !fe_cmd_fence_i) begin
                    w_state_n = e_fseq_done;
                end
            end
            e_fseq_done: w_state_n = e_fseq_idle;
            default:     w_state_n = e_fseq_idle;
        endcase
    end

    // Counter is held clear outside DRAIN/WAIT_FE, so it starts from zero on entry to either.
    assign w_counting = (r_state == e_fseq_drain) || (r_state == e_fseq_wait_fe);

    bp_be_fence_watchdog #(
        .timeout_p (timeout_p)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (!w_counting),
        .en_i      (w_counting),
        .count_o   (w_wd_cnt),
        .timeout_o (w_wd_timeout)
    );

    assign fence_ready_o = (r_state == e_fseq_idle);
    assign busy_o        = (r_state != e_fseq_idle);
    assign dtlb_flush_o  = (r_state == e_fseq_flush);
    assign fe_cmd_v_o    = (r_state == e_fseq_send);
    assign fe_cmd_op_o   = (r_state != e_fseq_send)  ? e_fe_op_none :
                           (r_type == e_sfence_vma)  ? e_fe_op_itlb_fence :
                                                       e_fe_op_icache_fence;
    assign fe_cmd_pc_o   = r_pc;
    assign fence_done_o  = (r_state == e_fseq_done);
    assign timeout_o     = w_wd_timeout;

endmodule

// File: tb/tb_bp_be_fence_sequencer.sv
// Randomized and directed fence sequences checked against a cycle-offset model of the fence protocol.
module tb_bp_be_fence_sequencer;

    localparam int VA = 39;
    localparam int TO = 16;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           fence_v_i;
    logic           fence_ready_o;
    logic [1:0]     fence_type_i;
    logic [VA-1:0]  fence_npc_i;
    logic           busy_o;
    logic           credits_empty_i;
    logic           dcache_idle_i;
    logic           dtlb_flush_o;
    logic           fe_cmd_v_o;
    logic [1:0]     fe_cmd_op_o;
    logic [VA-1:0]  fe_cmd_pc_o;
    logic           fe_cmd_ready_i;
    logic           fe_cmd_fence_i;
    logic           fence_done_o;
    logic           timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_timeout = 1'b0;

    always #5 clk_i = ~clk_i;

    bp_be_fence_sequencer #(
        .vaddr_width_p (VA),
        .timeout_p     (TO)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .fence_v_i       (fence_v_i),
        .fence_ready_o   (fence_ready_o),
        .fence_type_i    (fence_type_i),
        .fence_npc_i     (fence_npc_i),
        .busy_o          (busy_o),
        .credits_empty_i (credits_empty_i),
        .dcache_idle_i   (dcache_idle_i),
        .dtlb_flush_o    (dtlb_flush_o),
        .fe_cmd_v_o      (fe_cmd_v_o),
        .fe_cmd_op_o     (fe_cmd_op_o),
        .fe_cmd_pc_o     (fe_cmd_pc_o),
        .fe_cmd_ready_i  (fe_cmd_ready_i),
        .fe_cmd_fence_i  (fe_cmd_fence_i),
        .fence_done_o    (fence_done_o),
        .timeout_o       (timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VA-1:0] rand_pc();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return x[VA-1:0];
    endfunction

    // Drain is blocked for cycles 1..d after accept, by credits, D$ activity, or both.
    task automatic drive_drain(input int c, input int d);
        int pick;
        if (c <= d) begin
            pick = int'($urandom_range(0, 2));
            credits_empty_i = (pick == 1);
            dcache_idle_i   = (pick == 0);
        end else begin
            credits_empty_i = 1'b1;
            dcache_idle_i   = 1'b1;
        end
    endtask

    // Cycle 0 is the accept cycle; d = blocked drain cycles, r = SEND cycles with ready low,
    // f = cycles the FE reports fence-in-progress after the transfer.
    task automatic run_fence(input logic [1:0] t, input logic [VA-1:0] pc,
                             input int d, input int r, input int f, input bit hold);
        int e_flush, e_send, e_xfer, e_done, e_rise, kstar;
        int o_done, o_flush_n, o_flush_c, o_first_v, o_xfer_n, o_xfer_c, o_busy, o_ready_n, o_rise;
        int vcnt;
        bit op_ok, pc_ok, op_idle_ok, prev_to;
        logic [1:0] exp_op;

        e_flush = -1; e_send = -1; e_xfer = -1; kstar = 0;
        if (t == 2'd2) begin
            e_flush = d + 2;
            e_send  = d + 3;
        end else if (t == 2'd1) begin
            e_send = d + 2;
        end
        if (e_send >= 0) begin
            e_xfer = e_send + r;
            kstar  = (f + 1 > 2) ? f + 1 : 2;
            e_done = e_xfer + kstar + 1;
        end else begin
            e_done = d + 2;
        end
        e_rise = -1;
        if (!exp_timeout) begin
            if (d + 1 >= TO) e_rise = TO + 1;
            else if (e_send >= 0 && kstar >= TO) e_rise = e_xfer + TO + 1;
        end
        exp_op = (t == 2'd2) ? 2'd2 : 2'd1;

        o_done = -1; o_flush_n = 0; o_flush_c = -1; o_first_v = -1; o_xfer_n = 0;
        o_xfer_c = -1; o_busy = 0; o_ready_n = 0; o_rise = -1; vcnt = 0;
        op_ok = 1'b1; pc_ok = 1'b1; op_idle_ok = 1'b1;

        @(negedge clk_i);
        chk("idle_ready", {63'd0, fence_ready_o}, 64'd1);
        chk("idle_busy",  {63'd0, busy_o}, 64'd0);
        chk("idle_done",  {63'd0, fence_done_o}, 64'd0);
        prev_to         = timeout_o;
        fence_v_i       = 1'b1;
        fence_type_i    = t;
        fence_npc_i     = pc;
        fe_cmd_ready_i  = 1'b0;
        fe_cmd_fence_i  = 1'b0;
        drive_drain(0, d);

        for (int c = 1; c <= 300 && o_done < 0; c++) begin
            @(negedge clk_i);
            if (busy_o) o_busy++;
            if (fence_ready_o) o_ready_n++;
            if (dtlb_flush_o) begin
                o_flush_n++;
                o_flush_c = c;
            end
            if (timeout_o && !prev_to && o_rise < 0) o_rise = c;
            prev_to = timeout_o;
            if (fe_cmd_v_o) begin
                if (o_first_v < 0) o_first_v = c;
                if (fe_cmd_op_o !== exp_op) op_ok = 1'b0;
                if (fe_cmd_pc_o !== pc) pc_ok = 1'b0;
            end else if (fe_cmd_op_o !== 2'd0) begin
                op_idle_ok = 1'b0;
            end
            if (fence_done_o) o_done = c;

            fence_v_i    = hold;
            fence_type_i = 2'($urandom());
            fence_npc_i  = rand_pc();
            drive_drain(c, d);
            fe_cmd_ready_i = fe_cmd_v_o && (vcnt >= r);
            if (fe_cmd_v_o) vcnt++;
            if (fe_cmd_v_o && fe_cmd_ready_i) begin
                o_xfer_n++;
                o_xfer_c = c;
            end
            fe_cmd_fence_i = (o_xfer_c >= 0) && (c >= o_xfer_c + 1) && (c <= o_xfer_c + f);
        end
        fe_cmd_fence_i = 1'b0;

        if (e_rise >= 0) exp_timeout = 1'b1;
        chk("done_cycle",   64'(o_done),    64'(e_done));
        chk("busy_cycles",  64'(o_busy),    64'(e_done));
        chk("ready_busy",   64'(o_ready_n), 64'd0);
        chk("flush_count",  64'(o_flush_n), (t == 2'd2) ? 64'd1 : 64'd0);
        chk("flush_cycle",  64'(o_flush_c), 64'(e_flush));
        chk("send_cycle",   64'(o_first_v), 64'(e_send));
        chk("xfer_count",   64'(o_xfer_n),  (e_send >= 0) ? 64'd1 : 64'd0);
        chk("xfer_cycle",   64'(o_xfer_c),  64'(e_xfer));
        chk("cmd_op",       {63'd0, op_ok}, 64'd1);
        chk("cmd_pc",       {63'd0, pc_ok}, 64'd1);
        chk("op_idle_zero", {63'd0, op_idle_ok}, 64'd1);
        chk("timeout_rise", 64'(o_rise),    64'(e_rise));
        chk("timeout_flag", {63'd0, timeout_o}, {63'd0, exp_timeout});
    endtask

    initial begin
        logic [1:0] rt;
        int rd, rr, rf;
        bit rh;

        reset_n_i       = 1'b0;
        fence_v_i       = 1'b0;
        fence_type_i    = 2'd0;
        fence_npc_i     = '0;
        credits_empty_i = 1'b1;
        dcache_idle_i   = 1'b1;
        fe_cmd_ready_i  = 1'b0;
        fe_cmd_fence_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready",   {63'd0, fence_ready_o}, 64'd1);
        chk("rst_busy",    {63'd0, busy_o}, 64'd0);
        chk("rst_flush",   {63'd0, dtlb_flush_o}, 64'd0);
        chk("rst_cmd_v",   {63'd0, fe_cmd_v_o}, 64'd0);
        chk("rst_cmd_op",  {62'd0, fe_cmd_op_o}, 64'd0);
        chk("rst_cmd_pc",  64'(fe_cmd_pc_o), 64'd0);
        chk("rst_done",    {63'd0, fence_done_o}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_o}, 64'd0);
        reset_n_i = 1'b1;

        // Plain fence, fence.i with back-pressure, sfence.vma.
        run_fence(2'd0, rand_pc(), 0, 0, 0, 1'b0);
        run_fence(2'd1, 39'h0080000040, 5, 3, 4, 1'b0);
        run_fence(2'd2, rand_pc(), 0, 1, 1, 1'b0);
        run_fence(2'd3, rand_pc(), 2, 0, 0, 1'b0);

        // Request held high through whole sequences: next accept only right after done.
        run_fence(2'd1, rand_pc(), 0, 0, 0, 1'b1);
        run_fence(2'd0, rand_pc(), 0, 0, 0, 1'b1);
        run_fence(2'd2, rand_pc(), 1, 2, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rt = 2'($urandom_range(0, 3));
            rd = int'($urandom_range(0, 6));
            rr = int'($urandom_range(0, 4));
            rf = int'($urandom_range(0, 6));
            rh = 1'($urandom_range(0, 1));
            run_fence(rt, rand_pc(), rd, rr, rf, rh);
        end

        // Watchdog in DRAIN; the fence still completes once D$ goes idle.
        run_fence(2'd0, rand_pc(), 20, 0, 0, 1'b0);
        run_fence(2'd0, rand_pc(), 0, 0, 0, 1'b0);

        // Reset while the FE command is pending.
        @(negedge clk_i);
        fence_v_i      = 1'b1;
        fence_type_i   = 2'd1;
        fence_npc_i    = rand_pc();
        fe_cmd_ready_i = 1'b0;
        @(negedge clk_i);
        fence_v_i = 1'b0;
        for (int i = 0; i < 10 && !fe_cmd_v_o; i++) @(negedge clk_i);
        chk("rst_mid_send_reached", {63'd0, fe_cmd_v_o}, 64'd1);
        #1 reset_n_i = 1'b0;
        #1;
        chk("rst_mid_cmd_v",   {63'd0, fe_cmd_v_o}, 64'd0);
        chk("rst_mid_busy",    {63'd0, busy_o}, 64'd0);
        chk("rst_mid_ready",   {63'd0, fence_ready_o}, 64'd1);
        chk("rst_mid_op",      {62'd0, fe_cmd_op_o}, 64'd0);
        chk("rst_mid_timeout", {63'd0, timeout_o}, 64'd0);
        exp_timeout = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Watchdog in WAIT_FE, then an ordinary fence.i after the abandoned one.
        run_fence(2'd1, rand_pc(), 0, 0, 17, 1'b0);
        run_fence(2'd1, rand_pc(), 1, 1, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
